// File: rtl/axi4_lite_read_master_if.sv
// AXI4-lite read channels (AR + R) between a read master and a read slave.
interface axi4_lite_read_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr,
        output arvalid,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid,
        output rready
    );

    modport slave (
        input  araddr,
        input  arvalid,
        output arready,
        output rdata,
        output rresp,
        output rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_read_master.sv
// Single-outstanding AXI4-lite read master with transaction, error and
// last-read latency counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a core request; req_ready high
// ST_ADDR | ARVALID high with the captured address held stable
// ST_DATA | RREADY high, waiting for the read data beat
// ST_RESP | one-cycle rsp_valid pulse; counters update
module axi4_lite_read_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [LAT_WIDTH-1:0]  last_latency,
    axi4_lite_read_master_if.master m_axi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  accept;
    logic                  ar_hs;
    logic                  r_hs;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [LAT_WIDTH-1:0]  lat_cnt;

    // EXOKAY carries no meaning for this master; only RRESP[1] is used.
    logic rresp_unused;
    assign rresp_unused = m_axi.rresp[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi.arready) begin
                    ar_hs   = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_axi.rvalid) begin
                    r_hs    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Channel strobes decode straight from state so reset drops them at once.
    assign m_axi.arvalid = (state_q == ST_ADDR);
    assign m_axi.rready  = (state_q == ST_DATA);
    assign m_axi.araddr  = araddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q <= '0;
            lat_cnt  <= '0;
        end else if (accept) begin
            araddr_q <= req_addr;
            lat_cnt  <= LAT_WIDTH'(1);
        end else if ((state_q == ST_ADDR || state_q == ST_DATA) && (lat_cnt != '1)) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            last_latency <= '0;
        end else if (r_hs) begin
            rsp_data     <= m_axi.rdata;
            rsp_err      <= m_axi.rresp[1];
            last_latency <= lat_cnt;
        end
    end

    // txn_count wraps naturally; err_count pins at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (state_q == ST_RESP) begin
            txn_count <= txn_count + 1'b1;
            if (rsp_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    logic ar_hs_unused;
    assign ar_hs_unused = ar_hs;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Directed bench for axi4_lite_read_master: full-width instance plus a narrow
// instance (4-bit counters, 4-bit latency) for wrap/saturation boundaries.
module tb_axi4_lite_read_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          failed = 0;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data, txn_count, err_count;
    logic [15:0] last_latency;

    logic        s_req_valid = 1'b0;
    logic [31:0] s_req_addr = '0;
    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_busy;
    logic [31:0] s_rsp_data;
    logic [3:0]  s_txn_count, s_err_count, s_last_latency;

    axi4_lite_read_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
    axi4_lite_read_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    always #5 clk = ~clk;

    axi4_lite_read_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32), .LAT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .txn_count(txn_count), .err_count(err_count), .last_latency(last_latency), .m_axi(m_if.master)
    );

    axi4_lite_read_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4), .LAT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy),
        .txn_count(s_txn_count), .err_count(s_err_count), .last_latency(s_last_latency), .m_axi(s_if.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read on the full-width instance; latency = ar_delay + r_delay + 2 edges.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input int ar_delay, input int r_delay);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr = addr;
        m_if.arready = (ar_delay == 0);
        m_if.rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = '0;
        for (int i = 0; i < ar_delay; i++) begin
            chk("stall_arvalid", {63'd0, m_if.arvalid}, 64'd1);
            chk("stall_araddr", {32'd0, m_if.araddr}, {32'd0, addr});
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        m_if.arready = 1'b1;
        chk("arvalid", {63'd0, m_if.arvalid}, 64'd1);
        chk("araddr", {32'd0, m_if.araddr}, {32'd0, addr});
        @(negedge clk);
        m_if.arready = 1'b0;
        for (int i = 0; i < r_delay; i++) begin
            chk("rready_wait", {63'd0, m_if.rready}, 64'd1);
            @(negedge clk);
        end
        m_if.rvalid = 1'b1;
        m_if.rdata = data;
        m_if.rresp = resp;
        @(negedge clk);
        m_if.rvalid = 1'b0;
        chk("rsp_valid_hi", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_data", {32'd0, rsp_data}, {32'd0, data});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, resp[1]});
        @(negedge clk);
        chk("rsp_valid_pulse", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;

        // reset state; a request during reset must not be captured
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = 32'h55;
        @(negedge clk);
        chk("rst_arvalid", {63'd0, m_if.arvalid}, 64'd0);
        chk("rst_rready", {63'd0, m_if.rready}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_araddr", {32'd0, m_if.araddr}, 64'd0);
        chk("rst_txn", {32'd0, txn_count}, 64'd0);
        chk("rst_lat", {48'd0, last_latency}, 64'd0);
        req_valid = 1'b0;
        req_addr = '0;
        rst = 1'b0;
        @(negedge clk);

        // single read
        do_read(32'h100, 32'hDEADBEEF, 2'b00, 0, 1);
        chk("t1_txn", {32'd0, txn_count}, 64'd1);
        chk("t1_lat", {48'd0, last_latency}, 64'd3);
        chk("t1_err", {32'd0, err_count}, 64'd0);

        // AR stall of 5 cycles
        do_read(32'h100, 32'h12345678, 2'b00, 5, 0);
        chk("t2_txn", {32'd0, txn_count}, 64'd2);
        chk("t2_lat", {48'd0, last_latency}, 64'd7);

        // error responses; EXOKAY alone is not an error
        do_read(32'h104, 32'hBAD0BAD0, 2'b10, 0, 1);
        chk("t3_err1", {32'd0, err_count}, 64'd1);
        do_read(32'h108, 32'h0BAD0BAD, 2'b11, 0, 0);
        chk("t3_err2", {32'd0, err_count}, 64'd2);
        chk("t3_lat", {48'd0, last_latency}, 64'd2);
        do_read(32'h10C, 32'h00C0FFEE, 2'b01, 0, 0);
        chk("t3_exokay_err", {32'd0, err_count}, 64'd2);
        chk("t3_txn", {32'd0, txn_count}, 64'd5);

        // back-to-back with req_valid held high
        m_if.arready = 1'b1;
        m_if.rvalid = 1'b1;
        m_if.rdata = 32'h1111_0000;
        m_if.rresp = 2'b00;
        req_valid = 1'b1;
        req_addr = 32'h0;
        @(negedge clk);
        chk("b2b_arvalid0", {63'd0, m_if.arvalid}, 64'd1);
        chk("b2b_araddr0", {32'd0, m_if.araddr}, 64'h0);
        chk("b2b_req_ready", {63'd0, req_ready}, 64'd0);
        chk("b2b_rready_in_addr", {63'd0, m_if.rready}, 64'd0);
        req_addr = 32'h4;
        @(negedge clk);
        chk("b2b_data_arvalid", {63'd0, m_if.arvalid}, 64'd0);
        chk("b2b_data_rready", {63'd0, m_if.rready}, 64'd1);
        @(negedge clk);
        chk("b2b_rsp0", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_rsp0_data", {32'd0, rsp_data}, 64'h1111_0000);
        chk("b2b_resp_arvalid", {63'd0, m_if.arvalid}, 64'd0);
        m_if.rdata = 32'h2222_0000;
        @(negedge clk);
        chk("b2b_idle_ready", {63'd0, req_ready}, 64'd1);
        chk("b2b_idle_arvalid", {63'd0, m_if.arvalid}, 64'd0);
        chk("b2b_txn6", {32'd0, txn_count}, 64'd6);
        @(negedge clk);
        chk("b2b_arvalid1", {63'd0, m_if.arvalid}, 64'd1);
        chk("b2b_araddr1", {32'd0, m_if.araddr}, 64'h4);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_rsp1", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_rsp1_data", {32'd0, rsp_data}, 64'h2222_0000);
        @(negedge clk);
        chk("b2b_txn7", {32'd0, txn_count}, 64'd7);
        m_if.rvalid = 1'b0;
        m_if.arready = 1'b0;

        // reset in ST_DATA
        m_if.arready = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        m_if.arready = 1'b0;
        chk("mid_rready", {63'd0, m_if.rready}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_arvalid", {63'd0, m_if.arvalid}, 64'd0);
        chk("mid_rready_rst", {63'd0, m_if.rready}, 64'd0);
        chk("mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_txn", {32'd0, txn_count}, 64'd0);
        chk("mid_err", {32'd0, err_count}, 64'd0);
        chk("mid_lat", {48'd0, last_latency}, 64'd0);
        chk("mid_rsp_data", {32'd0, rsp_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(32'h200, 32'hCAFEF00D, 2'b00, 0, 0);
        chk("post_rst_txn", {32'd0, txn_count}, 64'd1);
        chk("post_rst_lat", {48'd0, last_latency}, 64'd2);

        // narrow instance: 16 error reads, 4 cycles each
        s_if.arready = 1'b1;
        s_if.rvalid = 1'b1;
        s_if.rdata = 32'hA5A5_A5A5;
        s_if.rresp = 2'b10;
        s_req_valid = 1'b1;
        repeat (60) @(negedge clk);
        chk("s_txn15", {60'd0, s_txn_count}, 64'd15);
        chk("s_err15", {60'd0, s_err_count}, 64'd15);
        repeat (4) @(negedge clk);
        s_req_valid = 1'b0;
        chk("s_txn_wrap", {60'd0, s_txn_count}, 64'd0);
        chk("s_err_sat", {60'd0, s_err_count}, 64'd15);
        chk("s_lat2", {60'd0, s_last_latency}, 64'd2);

        // narrow instance: RVALID 20 cycles into ST_DATA saturates latency
        s_if.rvalid = 1'b0;
        s_if.rresp = 2'b00;
        s_req_valid = 1'b1;
        @(negedge clk);
        s_req_valid = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        chk("s_wait_rready", {63'd0, s_if.rready}, 64'd1);
        s_if.rvalid = 1'b1;
        @(negedge clk);
        s_if.rvalid = 1'b0;
        chk("s_rsp_valid", {63'd0, s_rsp_valid}, 64'd1);
        chk("s_rsp_err", {63'd0, s_rsp_err}, 64'd0);
        chk("s_lat_sat", {60'd0, s_last_latency}, 64'd15);
        @(negedge clk);
        chk("s_txn1", {60'd0, s_txn_count}, 64'd1);
        chk("s_err_hold", {60'd0, s_err_count}, 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
